// File: rtl/issue_scheduler.sv
// In-order issue queue between decode and the issue unit: buffers {unit-select, uOp}
// pairs and releases the oldest one to its execution unit when that unit is not busy.
module issue_scheduler #(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic             flush_in,
  input  logic             dec_valid_in,
  output logic             dec_ready_out,
  input  logic [3:0]       dec_unit_sel_in,
  input  logic [3:0]       dec_uop_in,
  input  logic             int_busy_in,
  input  logic             vec_busy_in,
  input  logic             lsu_busy_in,
  input  logic             bru_busy_in,
  output logic [3:0]       exec_unit_sel_out,
  output logic [3:0]       exec_uop_out,
  output logic             issue_valid_out,
  output logic             illegal_sel_out,
  output logic [OCC_W-1:0] occupancy_out,
  output logic [CNT_W-1:0] stall_count_out,
  output logic [1:0]       head_state_out
);

  typedef enum logic [1:0] {
    HS_EMPTY   = 2'd0,
    HS_ILLEGAL = 2'd1,
    HS_BLOCKED = 2'd2,
    HS_ISSUE   = 2'd3
  } head_state_t;

  logic [3:0]       sel_mem [DEPTH];
  logic [3:0]       uop_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;

  logic [3:0]  head_sel;
  logic [3:0]  head_uop;
  logic        sel_legal;
  logic        head_busy;
  head_state_t head_state;
  logic        push;
  logic        pop;

  // Decode handshake: an entry transfers on a rising edge where dec_valid_in and
  // dec_ready_out are both 1 (and no flush); ready depends only on stored state.
  assign dec_ready_out  = (count < OCC_W'(DEPTH));
  assign occupancy_out  = count;
  assign head_state_out = head_state;

  always_comb begin
    head_sel  = sel_mem[rd_ptr];
    head_uop  = uop_mem[rd_ptr];
    sel_legal = (head_sel == 4'b0001) || (head_sel == 4'b0010) ||
                (head_sel == 4'b0100) || (head_sel == 4'b1000);
    head_busy = 1'b0;
    case (head_sel)
      4'b0001: head_busy = int_busy_in;
      4'b0010: head_busy = bru_busy_in;
      4'b0100: head_busy = lsu_busy_in;
      4'b1000: head_busy = vec_busy_in;
      default: head_busy = 1'b0;
    endcase
    if (count == '0)     head_state = HS_EMPTY;
    else if (!sel_legal) head_state = HS_ILLEGAL;
    else if (head_busy)  head_state = HS_BLOCKED;
    else                 head_state = HS_ISSUE;
  end

  // Illegal heads are popped too, so a bad select cannot wedge the queue.
  assign pop  = !flush_in && ((head_state == HS_ILLEGAL) || (head_state == HS_ISSUE));
  assign push = !flush_in && dec_valid_in && dec_ready_out;

  always_ff @(posedge clock_in) begin
    if (push) begin
      sel_mem[wr_ptr] <= dec_unit_sel_in;
      uop_mem[wr_ptr] <= dec_uop_in;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      exec_unit_sel_out <= '0;
      exec_uop_out      <= '0;
      issue_valid_out   <= 1'b0;
      illegal_sel_out   <= 1'b0;
      stall_count_out   <= '0;
    end else begin
      exec_unit_sel_out <= '0;
      exec_uop_out      <= '0;
      issue_valid_out   <= 1'b0;
      illegal_sel_out   <= 1'b0;
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + OCC_W'(1);
          2'b01:   count <= count - OCC_W'(1);
          default: count <= count;
        endcase
        case (head_state)
          HS_ILLEGAL: illegal_sel_out <= 1'b1;
          HS_BLOCKED: if (stall_count_out != '1) stall_count_out <= stall_count_out + CNT_W'(1);
          HS_ISSUE: begin
            exec_unit_sel_out <= head_sel;
            exec_uop_out      <= head_uop;
            issue_valid_out   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the issue rules.
module tb_issue_scheduler;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush_in = 1'b0;
  logic       dec_valid_in = 1'b0;
  logic       dec_ready_out;
  logic [3:0] dec_unit_sel_in = '0;
  logic [3:0] dec_uop_in = '0;
  logic       int_busy_in = 1'b0;
  logic       vec_busy_in = 1'b0;
  logic       lsu_busy_in = 1'b0;
  logic       bru_busy_in = 1'b0;
  logic [3:0] exec_unit_sel_out;
  logic [3:0] exec_uop_out;
  logic       issue_valid_out;
  logic       illegal_sel_out;
  logic [2:0] occupancy_out;
  logic [7:0] stall_count_out;
  logic [1:0] head_state_out;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] exp_q[$];
  logic [3:0] e_sel = '0;
  logic [3:0] e_uop = '0;
  logic       e_iv = 1'b0;
  logic       e_ill = 1'b0;
  int         e_stall = 0;

  issue_scheduler #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clock_in(clk), .reset_n_in(reset_n), .flush_in(flush_in),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .dec_unit_sel_in(dec_unit_sel_in), .dec_uop_in(dec_uop_in),
    .int_busy_in(int_busy_in), .vec_busy_in(vec_busy_in),
    .lsu_busy_in(lsu_busy_in), .bru_busy_in(bru_busy_in),
    .exec_unit_sel_out(exec_unit_sel_out), .exec_uop_out(exec_uop_out),
    .issue_valid_out(issue_valid_out), .illegal_sel_out(illegal_sel_out),
    .occupancy_out(occupancy_out), .stall_count_out(stall_count_out),
    .head_state_out(head_state_out)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".sel"},   exec_unit_sel_out, e_sel);
    chk({tag, ".uop"},   exec_uop_out, e_uop);
    chk({tag, ".iv"},    issue_valid_out, e_iv);
    chk({tag, ".ill"},   illegal_sel_out, e_ill);
    chk({tag, ".occ"},   occupancy_out, exp_q.size());
    chk({tag, ".stall"}, stall_count_out, e_stall);
  endtask

  // One clock: predict the edge from the current inputs, advance, compare.
  task automatic step(input string tag);
    logic [3:0] hsel;
    logic [3:0] busy_vec;
    bit         accept;
    chk({tag, ".ready"}, dec_ready_out, exp_q.size() < DEPTH);
    busy_vec = {vec_busy_in, lsu_busy_in, bru_busy_in, int_busy_in};
    accept   = dec_valid_in && (exp_q.size() < DEPTH);
    e_sel = '0; e_uop = '0; e_iv = 1'b0; e_ill = 1'b0;
    if (flush_in) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        hsel = exp_q[0][7:4];
        if ($countones(hsel) != 1) begin
          void'(exp_q.pop_front());
          e_ill = 1'b1;
        end else if ((hsel & busy_vec) != 4'b0000) begin
          if (e_stall < 255) e_stall++;
        end else begin
          e_sel = hsel;
          e_uop = exp_q[0][3:0];
          e_iv  = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      if (accept) exp_q.push_back({dec_unit_sel_in, dec_uop_in});
    end
    @(posedge clk);
    #1;
    chk_outputs(tag);
  endtask

  task automatic push_step(input string tag, input logic [3:0] sel, input logic [3:0] uop);
    dec_valid_in = 1'b1; dec_unit_sel_in = sel; dec_uop_in = uop;
    step(tag);
    dec_valid_in = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    e_sel = '0; e_uop = '0; e_iv = 1'b0; e_ill = 1'b0; e_stall = 0;
  endtask

  initial begin
    logic [3:0] legal_sel[4];
    legal_sel[0] = 4'b0001; legal_sel[1] = 4'b0010;
    legal_sel[2] = 4'b0100; legal_sel[3] = 4'b1000;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    model_reset();
    chk_outputs("reset");
    chk("reset.ready", dec_ready_out, 1'b1);

    // 1: single issue, two edges after the push edge starts
    push_step("t1_push", 4'b0001, 4'h5);
    step("t1_issue");
    chk("t1.sel", exec_unit_sel_out, 4'b0001);
    chk("t1.uop", exec_uop_out, 4'h5);
    chk("t1.iv",  issue_valid_out, 1'b1);
    step("t1_after");
    chk("t1.iv_drop", issue_valid_out, 1'b0);

    // 2: fill with INT entries while INT is busy
    int_busy_in = 1'b1;
    for (int i = 0; i < 4; i++) push_step("t2_fill", 4'b0001, 4'(i + 1));
    chk("t2.ready_full", dec_ready_out, 1'b0);
    chk("t2.occ_full", occupancy_out, 3'd4);
    push_step("t2_fifth", 4'b0001, 4'hf);
    chk("t2.occ_still", occupancy_out, 3'd4);

    // 3: release INT; drains in push order
    int_busy_in = 1'b0;
    for (int i = 0; i < 5; i++) step("t3_drain");

    // 4: illegal head then VEC
    push_step("t4_bad", 4'b0110, 4'h3);
    push_step("t4_vec", 4'b1000, 4'h9);
    chk("t4.ill", illegal_sel_out, 1'b1);
    chk("t4.ill_sel", exec_unit_sel_out, 4'b0000);
    step("t4_issue");
    chk("t4.vec_sel", exec_unit_sel_out, 4'b1000);
    chk("t4.vec_uop", exec_uop_out, 4'h9);

    // 5: blocked LSU head holds back a free BRU entry
    lsu_busy_in = 1'b1;
    push_step("t5_lsu", 4'b0100, 4'h1);
    push_step("t5_bru", 4'b0010, 4'h2);
    for (int i = 0; i < 3; i++) step("t5_hold");
    chk("t5.no_issue", issue_valid_out, 1'b0);
    lsu_busy_in = 1'b0;
    for (int i = 0; i < 3; i++) step("t5_drain");

    // 6: flush with a push in the same cycle, then async reset mid-stream
    int_busy_in = 1'b1;
    for (int i = 0; i < 3; i++) push_step("t6_fill", 4'b0001, 4'(i + 7));
    flush_in = 1'b1; dec_valid_in = 1'b1; dec_unit_sel_in = 4'b0010; dec_uop_in = 4'hc;
    step("t6_flush");
    flush_in = 1'b0; dec_valid_in = 1'b0;
    chk("t6.occ0", occupancy_out, 3'd0);
    chk("t6.no_issue", issue_valid_out, 1'b0);
    int_busy_in = 1'b0;
    push_step("t6_push", 4'b0001, 4'ha);
    push_step("t6_push", 4'b0010, 4'hb);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("t6_async_reset");
    chk("t6.reset_ready", dec_ready_out, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      dec_valid_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) dec_unit_sel_in = 4'($urandom_range(0, 15));
      else dec_unit_sel_in = legal_sel[$urandom_range(0, 3)];
      dec_uop_in  = 4'($urandom_range(0, 15));
      int_busy_in = ($urandom_range(0, 2) == 0);
      vec_busy_in = ($urandom_range(0, 2) == 0);
      lsu_busy_in = ($urandom_range(0, 2) == 0);
      bru_busy_in = ($urandom_range(0, 2) == 0);
      flush_in    = ($urandom_range(0, 39) == 0);
      step("rand");
    end
    flush_in = 1'b0; dec_valid_in = 1'b0;
    int_busy_in = 1'b0; vec_busy_in = 1'b0; lsu_busy_in = 1'b0; bru_busy_in = 1'b0;
    for (int i = 0; i < 6; i++) step("rand_drain");

    // stall counter saturation
    int_busy_in = 1'b1;
    push_step("sat_push", 4'b0001, 4'h4);
    for (int i = 0; i < 270; i++) step("sat");
    chk("sat.stall_max", stall_count_out, 8'hff);
    int_busy_in = 1'b0;
    step("sat_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
